usb_status_din_arbiter: RTL and testbench

//  Shares the status-screen hex-dump byte channel (din/din_v into usb_annunciator) between
//  N_REQ byte producers (e.g. RX packet sniffer, TX sniffer, setup decoder).

---
 rtl/usb_status_din_arbiter.sv | 165 ++++++++++++++++
 tb/tb_usb_status_din_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_status_din_arbiter.sv
// Round-robin arbiter that merges N_REQ byte producers onto the annunciator's din/din_v
// channel. Each producer owns a 2-deep FIFO; every byte gets a fixed HOLD-high/GAP-low strobe.
module usb_status_din_arbiter #(
    parameter int N_REQ = 4,
    parameter int HOLD  = 4,
    parameter int GAP   = 2
) (
    input  logic                       clk48,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           ovf,
    input  logic                       ovf_clr,
    output logic [7:0]                 din,
    output logic                       din_v,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_GAP
    } state_t;

    state_t           state_reg;
    logic [3:0]       cnt_reg;
    logic [IW-1:0]    last_grant_reg;
    logic [IW-1:0]    grant_id_reg;
    logic [7:0]       din_reg;
    logic             din_v_reg;

    logic [N_REQ-1:0]   fifo_nonempty;
    logic [N_REQ-1:0]   pop_vec;
    logic [8*N_REQ-1:0] head_data;

    logic               sel_found;
    logic [IW-1:0]      sel_idx;
    logic [IW:0]        cand;

    // Per-requester 2-entry FIFO; q0 is always the head, q1 the second entry.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : gen_fifo
            logic [7:0] q0_reg;
            logic [7:0] q1_reg;
            logic [1:0] count_reg;
            logic       ovf_reg;
            logic       push;
            logic       pop;

            assign req_ready[gi]          = (count_reg != 2'd2);
            assign push                   = req_valid[gi] & req_ready[gi];
            assign pop                    = pop_vec[gi];
            assign fifo_nonempty[gi]      = (count_reg != 2'd0);
            assign head_data[8*gi +: 8]   = q0_reg;
            assign ovf[gi]                = ovf_reg;

            always_ff @(posedge clk48 or posedge rst) begin
                if (rst) begin
                    q0_reg    <= 8'd0;
                    q1_reg    <= 8'd0;
                    count_reg <= 2'd0;
                    ovf_reg   <= 1'b0;
                end else begin
                    if (pop) begin
                        q0_reg <= q1_reg;
                    end
                    // The new byte lands at the slot that is the tail after any pop.
                    if (push && (count_reg == 2'd0 || (count_reg == 2'd1 && pop))) begin
                        q0_reg <= req_data[8*gi +: 8];
                    end else if (push) begin
                        q1_reg <= req_data[8*gi +: 8];
                    end
                    case ({push, pop})
                        2'b10:   count_reg <= count_reg + 2'd1;
                        2'b01:   count_reg <= count_reg - 2'd1;
                        default: count_reg <= count_reg;
                    endcase
                    if (req_valid[gi] && !req_ready[gi]) begin
                        ovf_reg <= 1'b1;
                    end else if (ovf_clr) begin
                        ovf_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Scan last_grant+1 .. last_grant+N_REQ with explicit wrap so non-power-of-2 N_REQ works.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_grant_reg} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!sel_found && fifo_nonempty[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        pop_vec = '0;
        if (state_reg == ST_IDLE && sel_found) begin
            pop_vec[sel_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 4'd0;
            last_grant_reg <= IW'(N_REQ - 1);
            grant_id_reg   <= '0;
            din_reg        <= 8'd0;
            din_v_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sel_found) begin
                        din_reg        <= head_data[8*sel_idx +: 8];
                        grant_id_reg   <= sel_idx;
                        last_grant_reg <= sel_idx;
                        cnt_reg        <= 4'(HOLD - 1);
                        din_v_reg      <= 1'b1;
                        state_reg      <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_reg == 4'd0) begin
                        cnt_reg   <= 4'(GAP - 1);
                        din_v_reg <= 1'b0;
                        state_reg <= ST_GAP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    din_v_reg <= 1'b0;
                end
            endcase
        end
    end

    assign din      = din_reg;
    assign din_v    = din_v_reg;
    assign grant_id = grant_id_reg;
    assign busy     = (state_reg != ST_IDLE) || (|fifo_nonempty);

endmodule

// File: tb/tb_usb_status_din_arbiter.sv
// Directed bench for usb_status_din_arbiter: a 4-requester instance for the timing, overflow
// and reset cases, and a 3-requester instance for the saturated round-robin case.
module tb_usb_status_din_arbiter;

    logic        clk48;
    logic        rst;
    logic        ovf_clr;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  ovf;
    logic [7:0]  din;
    logic        din_v;
    logic [1:0]  grant_id;
    logic        busy;

    logic        ovf_clr3;
    logic [2:0]  req_valid3;
    logic [23:0] req_data3;
    logic [2:0]  req_ready3;
    logic [2:0]  ovf3;
    logic [7:0]  din3;
    logic        din_v3;
    logic [1:0]  grant_id3;
    logic        busy3;

    int checks   = 0;
    int failures = 0;

    usb_status_din_arbiter #(.N_REQ(4), .HOLD(4), .GAP(2)) u_dut (
        .clk48     (clk48),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .din       (din),
        .din_v     (din_v),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    usb_status_din_arbiter #(.N_REQ(3), .HOLD(4), .GAP(2)) u_dut3 (
        .clk48     (clk48),
        .rst       (rst),
        .req_valid (req_valid3),
        .req_data  (req_data3),
        .req_ready (req_ready3),
        .ovf       (ovf3),
        .ovf_clr   (ovf_clr3),
        .din       (din3),
        .din_v     (din_v3),
        .grant_id  (grant_id3),
        .busy      (busy3)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(negedge clk48);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_byte;
        logic [3:0] sq [3];
        logic [3:0] rc [3];
        logic       prev_v3;
        int         got;
        int         idx;

        rst        = 1'b1;
        ovf_clr    = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        ovf_clr3   = 1'b0;
        req_valid3 = '0;
        req_data3  = '0;
        tick();
        tick();

        // Reset state
        chk("rst_din", din, 8'h00);
        chk("rst_din_v", din_v, 1'b0);
        chk("rst_grant", grant_id, 2'd0);
        chk("rst_ovf", ovf, 4'h0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst_ready", req_ready, 4'hF);

        // Test 1: single byte envelope
        req_valid     = 4'b0001;
        req_data[7:0] = 8'hA5;
        tick();
        req_valid = '0;
        chk("t1_busy_n1", busy, 1'b1);
        chk("t1_dinv_n1", din_v, 1'b0);
        for (int k = 2; k <= 7; k++) begin
            tick();
            chk($sformatf("t1_dinv_n%0d", k), din_v, (k <= 5) ? 1 : 0);
            if (k == 2) begin
                chk("t1_din", din, 8'hA5);
                chk("t1_grant", grant_id, 2'd0);
            end
        end
        chk("t1_din_hold", din, 8'hA5);
        chk("t1_busy_n7", busy, 1'b1);
        tick();
        chk("t1_busy_n8", busy, 1'b0);

        // Test 2: four simultaneous pushes drain in order 0..3
        do_reset();
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        tick();
        req_valid = '0;
        for (int b = 0; b < 4; b++) begin
            tick();
            exp_byte = 8'(8'h11 * (b + 1));
            chk($sformatf("t2_din_b%0d", b), din, exp_byte);
            chk($sformatf("t2_grant_b%0d", b), grant_id, b);
            chk($sformatf("t2_dinv_b%0d", b), din_v, 1'b1);
            repeat (6) tick();
            chk($sformatf("t2_gap_b%0d", b), din_v, 1'b0);
        end
        chk("t2_busy_end", busy, 1'b0);
        chk("t2_ovf", ovf, 4'h0);

        // Test 3: req 2 overflows its FIFO while req 1 is on the wire
        do_reset();
        req_valid = 4'b0010;
        req_data  = 32'h0000_7700;
        tick();
        req_valid = 4'b0100;
        req_data  = 32'h0001_0000;
        tick();
        chk("t3_din_r1", din, 8'h77);
        chk("t3_grant_r1", grant_id, 2'd1);
        chk("t3_ready2_n2", req_ready[2], 1'b1);
        req_data = 32'h0002_0000;
        tick();
        chk("t3_ready2_n3", req_ready[2], 1'b0);
        chk("t3_ovf_n3", ovf, 4'h0);
        req_data = 32'h0003_0000;
        tick();
        req_valid = '0;
        chk("t3_ovf_n4", ovf, 4'b0100);
        repeat (5) tick();
        chk("t3_din_01", din, 8'h01);
        chk("t3_grant_01", grant_id, 2'd2);
        chk("t3_dinv_01", din_v, 1'b1);
        repeat (7) tick();
        chk("t3_din_02", din, 8'h02);
        chk("t3_grant_02", grant_id, 2'd2);
        repeat (6) tick();
        chk("t3_busy_end", busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t3_no03_%0d", k), din_v, 1'b0);
        end

        // Test 4: a fresh overflow beats ovf_clr in the same cycle
        req_valid = 4'b0100;
        req_data  = 32'h00AA_0000;
        tick();
        req_data = 32'h00BB_0000;
        tick();
        chk("t4_din_aa", din, 8'hAA);
        chk("t4_ready2_m2", req_ready[2], 1'b1);
        req_data = 32'h00CC_0000;
        tick();
        chk("t4_ready2_m3", req_ready[2], 1'b0);
        req_data = 32'h00DD_0000;
        ovf_clr  = 1'b1;
        tick();
        chk("t4_ovf_set_wins", ovf, 4'b0100);
        req_valid = '0;
        tick();
        chk("t4_ovf_cleared", ovf, 4'h0);
        ovf_clr = 1'b0;
        repeat (4) tick();
        chk("t4_din_bb", din, 8'hBB);
        repeat (7) tick();
        chk("t4_din_cc", din, 8'hCC);
        chk("t4_grant_cc", grant_id, 2'd2);
        repeat (6) tick();
        chk("t4_busy_end", busy, 1'b0);

        // Test 5: reset mid-byte discards the queue and restores priority
        req_valid = 4'b0111;
        req_data  = 32'h007C_6B5A;
        tick();
        req_valid = '0;
        tick();
        chk("t5_din_5a", din, 8'h5A);
        chk("t5_grant_0", grant_id, 2'd0);
        tick();
        chk("t5_dinv_2nd", din_v, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_async_dinv", din_v, 1'b0);
        chk("t5_async_din", din, 8'h00);
        chk("t5_async_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("t5_quiet_%0d", k), din_v, 1'b0);
        end
        chk("t5_busy_quiet", busy, 1'b0);
        req_valid = 4'b1000;
        req_data  = 32'h3C00_0000;
        tick();
        req_valid = '0;
        tick();
        chk("t5_din_3c", din, 8'h3C);
        chk("t5_grant_3", grant_id, 2'd3);
        chk("t5_dinv_3c", din_v, 1'b1);

        // Test 6: N_REQ=3 saturated, grants rotate 0,1,2
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sq[i] = 4'd0;
            rc[i] = 4'd0;
        end
        prev_v3 = 1'b0;
        got     = 0;
        for (int c = 0; c < 400 && got < 30; c++) begin
            if (din_v3 && !prev_v3) begin
                idx      = got % 3;
                exp_byte = {4'(idx), rc[idx]};
                chk($sformatf("t6_grant_%0d", got), grant_id3, idx);
                chk($sformatf("t6_din_%0d", got), din3, exp_byte);
                rc[idx] = rc[idx] + 4'd1;
                got++;
            end
            prev_v3 = din_v3;
            req_valid3 = req_ready3;
            for (int i = 0; i < 3; i++) begin
                if (req_ready3[i]) begin
                    req_data3[8*i +: 8] = {4'(i), sq[i]};
                    sq[i] = sq[i] + 4'd1;
                end
            end
            tick();
        end
        req_valid3 = '0;
        chk("t6_bytes_seen", got, 30);
        chk("t6_ovf", ovf3, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
